// File: rtl/tt_um_hoene_smart_led_pkg.sv
// Shared types for the smart-LED receive path: FSM states, bit phase and interval classes.
package tt_um_hoene_smart_led_pkg;

  typedef enum logic [1:0] {StIdle, StTrain, StHunt, StData} rx_state_e;

  typedef enum logic {PhMid, PhBoundary} phase_e;

  typedef enum logic [1:0] {IvGlitch, IvShort, IvLong, IvOver} ival_e;

  // Thresholds sit halfway between the nominal H and 2H interval lengths.
  function automatic ival_e classify(input logic [31:0] cnt, input logic [31:0] half_period);
    logic [31:0] h2;
    h2 = half_period >> 1;
    if (cnt < h2) return IvGlitch;
    if (cnt < half_period + h2) return IvShort;
    if (cnt < (half_period << 1) + h2) return IvLong;
    return IvOver;
  endfunction

endpackage

// File: rtl/tt_um_hoene_edge_timer.sv
// Two-flop edge detector with a saturating counter of clk cycles since the last edge.
module tt_um_hoene_edge_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_i,
  output logic            edge_o,
  output logic            rise_o,
  output logic [CntW-1:0] cnt_o
);

  logic            in_q, in_qq;
  logic [CntW-1:0] cnt_q;

  assign edge_o = in_q ^ in_qq;
  assign rise_o = in_q & ~in_qq;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= 1'b0;
      in_qq <= 1'b0;
      cnt_q <= '0;
    end else begin
      in_q  <= in_i;
      in_qq <= in_q;
      if (edge_o) begin
        cnt_q <= CntW'(1);
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/tt_um_hoene_manchester_rx.sv
// Manchester receiver: learns the half-period from a '1' preamble, then decodes MSB-first words
// after a '0' start bit. Strobes and sync state are registered once more so they line up.
module tt_um_hoene_manchester_rx
  import tt_um_hoene_smart_led_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned WORD_W      = 24,
  parameter int unsigned TRAIN_EDGES = 8,
  parameter int unsigned MIN_HALF    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_error,
  output logic              out_insync,
  output logic [CNT_W-1:0]  out_pulsewidth
);

  localparam int unsigned TrainLog = $clog2(TRAIN_EDGES);
  localparam int unsigned SumW     = CNT_W + TrainLog;
  localparam int unsigned NW       = TrainLog + 1;
  localparam int unsigned BW       = $clog2(WORD_W);
  localparam int unsigned XW       = CNT_W + 2;
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [NW-1:0]    NFull   = NW'(TRAIN_EDGES);
  localparam logic [CNT_W-1:0] MinH    = CNT_W'(MIN_HALF);
  localparam logic [BW-1:0]    LastBit = BW'(WORD_W - 1);

  logic             line_edge, line_rise;
  logic [CNT_W-1:0] cnt;

  tt_um_hoene_edge_timer #(
    .CntW (CNT_W)
  ) u_edge_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (in),
    .edge_o (line_edge),
    .rise_o (line_rise),
    .cnt_o  (cnt)
  );

  rx_state_e         state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  ref_q, ref_d, h_q, h_d;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [NW-1:0]     n_q, n_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d, data_q, data_d;
  logic              valid_q, valid_d, error_q, error_d;

  logic [XW-1:0]    cnt_x, ref_x, h_x, three_h, limit_x, tol_lo, tol_hi;
  logic             in_tol, timeout, mid_edge, bad_edge;
  logic [CNT_W-1:0] h_est;
  ival_e            cls;

  assign cnt_x   = XW'(cnt);
  assign ref_x   = XW'(ref_q);
  assign h_x     = XW'(h_q);
  assign three_h = (h_x << 1) + h_x;
  // A 3H beyond the counter range would never match, so time out at saturation instead.
  assign limit_x = (three_h > XW'(CntMax)) ? XW'(CntMax) : three_h;
  assign tol_lo  = ref_x - (ref_x >> 2);
  assign tol_hi  = ref_x + (ref_x >> 2);
  assign in_tol  = (cnt_x >= tol_lo) && (cnt_x <= tol_hi);
  assign timeout = ((state_q == StHunt) || (state_q == StData)) && (cnt_x == limit_x);
  assign cls     = classify(32'(cnt), 32'(h_q));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    ref_d    = ref_q;
    sum_d    = sum_q;
    n_d      = n_q;
    h_d      = h_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    h_est    = '0;
    mid_edge = 1'b0;
    bad_edge = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (line_edge) begin
          state_d = StTrain;
          ref_d   = '0;
          sum_d   = '0;
          n_d     = '0;
        end
      end
      StTrain: begin
        if (cnt == CntMax) begin
          state_d = StIdle;
        end else if (line_edge) begin
          if (ref_q != '0 && in_tol) begin
            if (n_q != NFull) begin
              sum_d = sum_q + SumW'(cnt);
              n_d   = n_q + NW'(1);
            end
          end else begin
            ref_d = cnt;
            sum_d = SumW'(cnt);
            n_d   = NW'(1);
          end
          if (line_rise && n_d == NFull) begin
            h_est = sum_d[SumW-1:TrainLog];
            if (h_est < MinH) begin
              ref_d = '0;
              sum_d = '0;
              n_d   = '0;
            end else begin
              h_d     = h_est;
              phase_d = PhMid;
              state_d = StHunt;
            end
          end
        end
      end
      StHunt, StData: begin
        if (timeout) begin
          state_d  = StIdle;
          error_d  = (bitcnt_q != '0);
          bitcnt_d = '0;
        end else if (line_edge) begin
          unique case (cls)
            IvGlitch: bad_edge = 1'b1;
            IvShort: begin
              if (phase_q == PhMid) begin
                phase_d = PhBoundary;
              end else begin
                phase_d  = PhMid;
                mid_edge = 1'b1;
              end
            end
            IvLong: begin
              if (phase_q == PhMid) mid_edge = 1'b1;
              else bad_edge = 1'b1;
            end
            IvOver: bad_edge = 1'b1;
          endcase

          if (bad_edge) begin
            error_d  = 1'b1;
            state_d  = StIdle;
            bitcnt_d = '0;
          end else if (mid_edge) begin
            if (state_q == StHunt) begin
              if (!line_rise) begin
                state_d  = StData;
                bitcnt_d = '0;
              end
            end else begin
              shreg_d = {shreg_q[WORD_W-2:0], line_rise};
              if (bitcnt_q == LastBit) begin
                data_d   = shreg_d;
                valid_d  = 1'b1;
                bitcnt_d = '0;
              end else begin
                bitcnt_d = bitcnt_q + BW'(1);
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      phase_q        <= PhMid;
      ref_q          <= '0;
      sum_q          <= '0;
      n_q            <= '0;
      h_q            <= '0;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      error_q        <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_error      <= 1'b0;
      out_insync     <= 1'b0;
      out_pulsewidth <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      ref_q          <= ref_d;
      sum_q          <= sum_d;
      n_q            <= n_d;
      h_q            <= h_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      error_q        <= error_d;
      out_data       <= data_q;
      out_valid      <= valid_q;
      out_error      <= error_q;
      out_insync     <= (state_q == StHunt) || (state_q == StData);
      out_pulsewidth <= h_q;
    end
  end

endmodule

// File: doc/tt_um_hoene_manchester_rx.md
Name: tt_um_hoene_manchester_rx

Overview:
Parametrised successor to the fixed-width Manchester decoder. It learns the bit half-period from a preamble of '1' bits, then tracks the mid-bit phase and hunts for a '0' start bit. After the start bit it assembles WORD_W-bit words MSB first, with a valid strobe per word. It sits after the low-pass filter and replaces both the decoder and the insync stage, reporting sync state, errors and the learned half-period.

Parameters:
CNT_W, 8, width of the interval counter and of out_pulsewidth; the counter saturates at 2^CNT_W-1.
WORD_W, 24, bits per output word (default is one RGB LED).
TRAIN_EDGES, 8, number of consistent short intervals averaged during training; must be a power of two, at least 2.
MIN_HALF, 3, smallest accepted learned half-period in clk cycles; a smaller estimate restarts training.

Ports:
clk  input  1  clock; single clock domain.
rst_n  input  1  reset, asynchronous, active-low.
in  input  1  filtered line level; already synchronous to clk.
out_data  output  WORD_W  last completed word; held until the next word.
out_valid  output  1  one-cycle strobe when out_data updates.
out_error  output  1  one-cycle strobe on a protocol error.
out_insync  output  1  high while in HUNT or DATA.
out_pulsewidth  output  CNT_W  learned half-period H in clk cycles; held.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, counters 0, in_q and in_qq loaded with 0.
- Edge detection: in_q<=in; in_qq<=in_q; edge=in_q^in_qq; rising=in_q&~in_qq.
- Interval counter cnt: cleared to 1 on an edge, otherwise incremented, saturating. cnt at an edge equals the clk cycles since the previous edge.
- Line coding: '1' is a rising edge at mid-bit, '0' is a falling edge at mid-bit.
- IDLE: on the first edge go to TRAIN; ref, sum and n are cleared.
- TRAIN:
  - First interval sets ref=cnt.
  - Each interval in [ref-ref/4, ref+ref/4] adds to sum and increments n.
  - Any other interval restarts training with that interval as the new ref.
  - When n reaches TRAIN_EDGES on a rising edge: H=sum>>log2(TRAIN_EDGES).
    - If H<MIN_HALF, restart training.
    - Otherwise out_pulsewidth=H, phase=MID, go to HUNT.
  - If cnt saturates, go to IDLE with no error.
- Interval classes, evaluated at each edge in HUNT and DATA:
  - cnt<H/2: GLITCH.
  - cnt<H+H/2: SHORT.
  - cnt<2H+H/2: LONG.
  - Otherwise: error.
- Phase tracking:
  - From MID: SHORT moves to BOUNDARY; LONG is a new mid-bit edge.
  - From BOUNDARY: SHORT is a mid-bit edge; LONG or GLITCH is an error.
  - GLITCH from any phase is an error.
  - At each mid-bit edge, bit=rising.
- HUNT: decoded '1' bits are ignored. A decoded '0' (start bit) goes to DATA with bitcnt=0.
- DATA:
  - Each decoded bit shifts into shreg from the LSB side, so the first received bit ends as the MSB; bitcnt increments.
  - When bitcnt reaches WORD_W: out_data<=shreg, out_valid pulses, bitcnt=0.
  - Following words continue back-to-back with no new start bit.
- Timeout at cnt==3H in HUNT or DATA:
  - If bitcnt==0, this is normal end of frame: go to IDLE with no error.
  - If bitcnt!=0, pulse out_error and go to IDLE.
- Error: out_error pulses one cycle, the partial word is discarded, state goes to IDLE, out_insync drops in the same cycle. out_data and out_pulsewidth are kept.
- Simultaneous edge and timeout (cnt==3H on the edge cycle): timeout wins.
- Simultaneous error and word completion cannot occur, because completion requires a valid mid-bit edge.
- Latency: out_valid and out_error assert exactly 2 clk after the first clk edge that samples the deciding transition of in.
- Reset mid-frame: immediate return to reset values; no strobe is emitted.
- Arithmetic: sum has width CNT_W+log2(TRAIN_EDGES). Threshold sums are computed at CNT_W+2 bits, so they cannot overflow.

Decomposition:
- Shared package tt_um_hoene_smart_led_pkg holds:
  - the state enum {IDLE, TRAIN, HUNT, DATA};
  - the phase enum {MID, BOUNDARY};
  - the interval-class enum {GLITCH, SHORT, LONG, OVER};
  - a function classify(cnt, H).
- One sub-module, tt_um_hoene_edge_timer (two-flop edge detect plus saturating cnt), is reusable by later blocks.

Test Plan:
- H=10 clk, 16 preamble '1's, '0' start bit, then 0xA5C3F0, then 40 idle clk -> exactly one out_valid with out_data=0xA5C3F0; out_pulsewidth=10; out_insync falls at the timeout; out_error never asserts.
- Same frame with half-bit widths alternating 9/11 clk -> identical word; out_pulsewidth=10.
- Two words, 0x123456 then 0xFEDCBA, back-to-back -> two out_valid strobes 480 clk apart, in order.
- 3-clk glitch pulse at data bit 5 (H=10) -> out_error pulse; out_insync=0; no out_valid; the next clean frame decodes correctly.
- Frame truncated after 12 data bits -> out_error at cnt==30, exactly 2 clk after the threshold sample; out_data keeps the prior word.
- rst_n pulsed low for 2 clk mid-word -> all outputs 0 immediately; a following full frame decodes with no spurious strobe.
